// File: rtl/dlx_ctrl_fsm.sv
// dlx_ctrl_fsm - multi-cycle DLX control FSM.
//
// Sequences one DLX instruction at a time through fetch, decode, execute,
// memory access and write-back. It supports R-type and I-type ALU ops,
// LW/SW, BEQZ/BNEZ and JR. Every datapath enable and memory strobe is a
// Moore output, decoded from the state register alone.
//
// Ports:
//   CLK, RESET          clock (rising edge); asynchronous active-high reset
//   STEP_EN             starts one instruction from INIT
//   CONT_MODE           1: on completion go straight to FETCH instead of INIT
//   OPCODE              IR[31:26]; stable outside FETCH
//   AEQZ                register A == 0
//   BUSY                memory busy
//   IR_EN..MDR_EN       register load enables
//   MDR_SEL, C_SEL      MDR / C source selects
//   ALU_IMM, ALU_ADD    ALU operand-2 immediate, forced add
//   GPR_WE, DST_SEL     GPR write enable, destination (0 rd, 1 rt)
//   PC_STEP, PC_LOAD    PC <= PC+4, PC <= (PC_SRC ? A : ALU)
//   PC_SRC, ADDR_SEL    PC load source, memory address source (0 PC, 1 MAR)
//   MR, MW, REQ         memory read, memory write, REQ = MR | MW
//   IN_INIT             state is INIT or HALT
//   STATE_O             current 4-bit state code
//   TIMEOUT_ERR         sticky memory-timeout flag
//
// Build option: define MEM_TIMEOUT_EN to abort any memory wait that lasts
// TIMEOUT_CYC busy cycles. The abort goes to HALT and sets TIMEOUT_ERR.
// Without this option the FSM waits on BUSY indefinitely and TIMEOUT_ERR is 0.
module dlx_ctrl_fsm #(
  parameter int unsigned          OPCODE_W    = 6,
  parameter logic [OPCODE_W-1:0]  LW_OP       = 6'h23,
  parameter logic [OPCODE_W-1:0]  SW_OP       = 6'h2B,
  parameter logic [OPCODE_W-1:0]  SPECIAL_OP  = 6'h00,
  parameter logic [OPCODE_W-1:0]  ALUI_LO     = 6'h08,
  parameter logic [OPCODE_W-1:0]  ALUI_HI     = 6'h0F,
  parameter logic [OPCODE_W-1:0]  BEQZ_OP     = 6'h04,
  parameter logic [OPCODE_W-1:0]  BNEZ_OP     = 6'h05,
  parameter logic [OPCODE_W-1:0]  JR_OP       = 6'h12,
  parameter int unsigned          TIMEOUT_CYC = 64
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                STEP_EN,
  input  logic                CONT_MODE,
  input  logic [OPCODE_W-1:0] OPCODE,
  input  logic                AEQZ,
  input  logic                BUSY,
  output logic                IR_EN,
  output logic                A_EN,
  output logic                B_EN,
  output logic                C_EN,
  output logic                MAR_EN,
  output logic                MDR_EN,
  output logic                MDR_SEL,
  output logic                C_SEL,
  output logic                ALU_IMM,
  output logic                ALU_ADD,
  output logic                GPR_WE,
  output logic                DST_SEL,
  output logic                PC_STEP,
  output logic                PC_LOAD,
  output logic                PC_SRC,
  output logic                ADDR_SEL,
  output logic                MR,
  output logic                MW,
  output logic                REQ,
  output logic                IN_INIT,
  output logic [3:0]          STATE_O,
  output logic                TIMEOUT_ERR
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_HALT   = 4'd3,
    S_ALU    = 4'd4,
    S_ALUI   = 4'd5,
    S_ADDR   = 4'd6,
    S_LOAD   = 4'd7,
    S_COPY   = 4'd8,
    S_SPREP  = 4'd9,
    S_STORE  = 4'd10,
    S_WBR    = 4'd11,
    S_WBI    = 4'd12,
    S_BRANCH = 4'd13,
    S_BTAKEN = 4'd14,
    S_JR     = 4'd15
  } state_t;

  state_t state_q, state_d;
  state_t done_st;
  logic   mem_wait;

  // Completion target, shared by every instruction's last state.
  assign done_st  = CONT_MODE ? S_FETCH : S_INIT;
  assign mem_wait = (state_q == S_FETCH) || (state_q == S_LOAD) || (state_q == S_STORE);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d = '0;
    err_d = err_q;
`endif
    unique case (state_q)
      S_INIT:   if (STEP_EN) state_d = S_FETCH;
      S_FETCH:  if (!BUSY) state_d = S_DECODE;
      S_DECODE: begin
        if (OPCODE == SPECIAL_OP)                           state_d = S_ALU;
        else if ((OPCODE >= ALUI_LO) && (OPCODE <= ALUI_HI)) state_d = S_ALUI;
        else if ((OPCODE == LW_OP) || (OPCODE == SW_OP))     state_d = S_ADDR;
        else if ((OPCODE == BEQZ_OP) || (OPCODE == BNEZ_OP)) state_d = S_BRANCH;
        else if (OPCODE == JR_OP)                            state_d = S_JR;
        else                                                 state_d = S_HALT;
      end
      S_HALT:   state_d = S_HALT;
      S_ALU:    state_d = S_WBR;
      S_ALUI:   state_d = S_WBI;
      S_ADDR:   state_d = (OPCODE == LW_OP) ? S_LOAD : S_SPREP;
      S_LOAD:   if (!BUSY) state_d = S_COPY;
      S_COPY:   state_d = S_WBI;
      S_SPREP:  state_d = S_STORE;
      S_STORE:  if (!BUSY) state_d = done_st;
      S_WBR:    state_d = done_st;
      S_WBI:    state_d = done_st;
      S_BRANCH: begin
        if ((OPCODE == BEQZ_OP) ? AEQZ : !AEQZ) state_d = S_BTAKEN;
        else                                   state_d = done_st;
      end
      S_BTAKEN: state_d = done_st;
      S_JR:     state_d = done_st;
      default:  state_d = S_INIT;
    endcase
`ifdef MEM_TIMEOUT_EN
    // The counter holds 0 outside memory waits, so every entry to
    // FETCH/LOAD/STORE starts the count from zero.
    if (mem_wait && BUSY) begin
      if (cnt_q == CNT_LAST) begin
        state_d = S_HALT;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign TIMEOUT_ERR = err_q;
`else
  assign TIMEOUT_ERR = 1'b0;
`endif

  // Moore output decode
  always_comb begin
    IR_EN    = 1'b0;
    A_EN     = 1'b0;
    B_EN     = 1'b0;
    C_EN     = 1'b0;
    MAR_EN   = 1'b0;
    MDR_EN   = 1'b0;
    MDR_SEL  = 1'b0;
    C_SEL    = 1'b0;
    ALU_IMM  = 1'b0;
    ALU_ADD  = 1'b0;
    GPR_WE   = 1'b0;
    DST_SEL  = 1'b0;
    PC_STEP  = 1'b0;
    PC_LOAD  = 1'b0;
    PC_SRC   = 1'b0;
    ADDR_SEL = 1'b0;
    MR       = 1'b0;
    MW       = 1'b0;
    unique case (state_q)
      S_FETCH:  begin MR = 1'b1; IR_EN = 1'b1; end
      S_DECODE: begin A_EN = 1'b1; B_EN = 1'b1; PC_STEP = 1'b1; end
      S_ALU:    C_EN = 1'b1;
      S_ALUI:   begin C_EN = 1'b1; ALU_IMM = 1'b1; end
      S_ADDR:   begin MAR_EN = 1'b1; ALU_IMM = 1'b1; ALU_ADD = 1'b1; end
      S_LOAD:   begin MR = 1'b1; ADDR_SEL = 1'b1; MDR_EN = 1'b1; end
      S_COPY:   begin C_EN = 1'b1; C_SEL = 1'b1; end
      S_SPREP:  begin MDR_EN = 1'b1; MDR_SEL = 1'b1; end
      S_STORE:  begin MW = 1'b1; ADDR_SEL = 1'b1; end
      S_WBR:    GPR_WE = 1'b1;
      S_WBI:    begin GPR_WE = 1'b1; DST_SEL = 1'b1; end
      S_BTAKEN: begin PC_LOAD = 1'b1; ALU_IMM = 1'b1; ALU_ADD = 1'b1; end
      S_JR:     begin PC_LOAD = 1'b1; PC_SRC = 1'b1; end
      default:  ;
    endcase
  end

  assign REQ     = mem_wait;
  assign IN_INIT = (state_q == S_INIT) || (state_q == S_HALT);
  assign STATE_O = state_q;

endmodule
